// File: rtl/axi4_to_mem_req_if.sv
// Bundle of the AXI4 slave channels and the memory request/response port of axi4_to_mem_req.
// The slave modport is the converter's view; master is the view of the AXI source plus the memory.
interface axi4_to_mem_req_if #(
    parameter int TAG = 1
);
    logic            axi_awvalid;
    logic            axi_awready;
    logic [TAG-1:0]  axi_awid;
    logic [31:0]     axi_awaddr;
    logic [2:0]      axi_awsize;
    logic [7:0]      axi_awlen;
    logic [1:0]      axi_awburst;

    logic            axi_wvalid;
    logic            axi_wready;
    logic [63:0]     axi_wdata;
    logic [7:0]      axi_wstrb;
    logic            axi_wlast;

    logic            axi_bvalid;
    logic            axi_bready;
    logic [1:0]      axi_bresp;
    logic [TAG-1:0]  axi_bid;

    logic            axi_arvalid;
    logic            axi_arready;
    logic [TAG-1:0]  axi_arid;
    logic [31:0]     axi_araddr;
    logic [2:0]      axi_arsize;
    logic [7:0]      axi_arlen;
    logic [1:0]      axi_arburst;

    logic            axi_rvalid;
    logic            axi_rready;
    logic [TAG-1:0]  axi_rid;
    logic [63:0]     axi_rdata;
    logic [1:0]      axi_rresp;
    logic            axi_rlast;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_write;
    logic [31:0]     mem_req_addr;
    logic [2:0]      mem_req_size;
    logic [63:0]     mem_req_wdata;
    logic [7:0]      mem_req_wstrb;
    logic            mem_rsp_valid;
    logic [63:0]     mem_rsp_rdata;
    logic            mem_rsp_error;

    modport slave (
        input  axi_awvalid, axi_awid, axi_awaddr, axi_awsize, axi_awlen, axi_awburst,
        output axi_awready,
        input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        output axi_wready,
        output axi_bvalid, axi_bresp, axi_bid,
        input  axi_bready,
        input  axi_arvalid, axi_arid, axi_araddr, axi_arsize, axi_arlen, axi_arburst,
        output axi_arready,
        output axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
        input  axi_rready,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_size,
        output mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_rdata, mem_rsp_error
    );

    modport master (
        output axi_awvalid, axi_awid, axi_awaddr, axi_awsize, axi_awlen, axi_awburst,
        input  axi_awready,
        output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        input  axi_wready,
        input  axi_bvalid, axi_bresp, axi_bid,
        output axi_bready,
        output axi_arvalid, axi_arid, axi_araddr, axi_arsize, axi_arlen, axi_arburst,
        input  axi_arready,
        input  axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
        output axi_rready,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_size,
        input  mem_req_wdata, mem_req_wstrb,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_rdata, mem_rsp_error
    );
endinterface

// File: rtl/axi4_to_mem_req.sv
// Single-beat AXI4 slave that turns each transaction into one memory request, one at a time.
//   state  | meaning
//   IDLE   | arbitrate held write/read, screen attributes
//   CMD    | mem_req_valid high, waiting for mem_req_ready
//   WAIT   | request accepted, waiting for mem_rsp_valid or timeout
//   RESP   | B or R response held until bready/rready
module axi4_to_mem_req #(
    parameter int TAG     = 1,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input logic               clk,
    input logic               rst_l,
    axi4_to_mem_req_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_RESP} state_e;

    localparam logic [1:0]      RESP_OK  = 2'b00;
    localparam logic [1:0]      RESP_ERR = 2'b10;
    localparam bit              TO_EN    = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e          state_q;
    logic            rr_last_rd_q;
    logic [TO_W-1:0] to_cnt_q;

    logic            aw_held_q;
    logic [TAG-1:0]  aw_id_q;
    logic [31:0]     aw_addr_q;
    logic [2:0]      aw_size_q;
    logic [7:0]      aw_len_q;
    logic [1:0]      aw_burst_q;

    logic            w_held_q;
    logic [63:0]     w_data_q;
    logic [7:0]      w_strb_q;
    logic            w_last_q;

    logic            ar_held_q;
    logic [TAG-1:0]  ar_id_q;
    logic [31:0]     ar_addr_q;
    logic [2:0]      ar_size_q;
    logic [7:0]      ar_len_q;
    logic [1:0]      ar_burst_q;

    logic            cur_wr_q;
    logic [TAG-1:0]  cur_id_q;

    logic            req_valid_q;
    logic            req_write_q;
    logic [31:0]     req_addr_q;
    logic [2:0]      req_size_q;
    logic [63:0]     req_wdata_q;
    logic [7:0]      req_wstrb_q;

    logic            bvalid_q;
    logic [1:0]      bresp_q;
    logic [TAG-1:0]  bid_q;
    logic            rvalid_q;
    logic [TAG-1:0]  rid_q;
    logic [63:0]     rdata_q;
    logic [1:0]      rresp_q;
    logic            rlast_q;

    logic            wr_elig, rd_elig, sel_wr, sel_err, sel_any;
    logic [TAG-1:0]  sel_id;
    logic [31:0]     sel_addr;
    logic [2:0]      sel_size;
    logic            to_hit;
    logic            rsp_fire, rsp_wr, rsp_err;
    logic [TAG-1:0]  rsp_id;
    logic [63:0]     rsp_data;
    logic            aw_take, w_take, ar_take;

    // Lane mask is the set of byte lanes a beat of this size at this offset may touch.
    function automatic logic is_illegal(input logic [7:0] len, input logic [1:0] burst,
                                        input logic [2:0] size, input logic [2:0] a_lo,
                                        input logic is_wr, input logic [7:0] strb,
                                        input logic last);
        logic [7:0] lane;
        logic       misal;
        logic       bad;
        lane  = 8'h00;
        misal = 1'b0;
        case (size)
            3'd0: lane = 8'h01 << a_lo;
            3'd1: begin lane = 8'h03 << a_lo; misal = a_lo[0];     end
            3'd2: begin lane = 8'h0F << a_lo; misal = |a_lo[1:0];  end
            3'd3: begin lane = 8'hFF;         misal = |a_lo;       end
            default: lane = 8'h00;
        endcase
        bad = (len != 8'd0) || (burst != 2'b01) || (size > 3'd3) || misal;
        if (is_wr) begin
            bad = bad || !last || (|(strb & ~lane));
        end
        return bad;
    endfunction

    assign bus.axi_awready = rst_l & ~aw_held_q;
    assign bus.axi_wready  = rst_l & ~w_held_q;
    assign bus.axi_arready = rst_l & ~ar_held_q;

    assign aw_take = bus.axi_awvalid & bus.axi_awready;
    assign w_take  = bus.axi_wvalid  & bus.axi_wready;
    assign ar_take = bus.axi_arvalid & bus.axi_arready;

    assign bus.axi_bvalid    = bvalid_q;
    assign bus.axi_bresp     = bresp_q;
    assign bus.axi_bid       = bid_q;
    assign bus.axi_rvalid    = rvalid_q;
    assign bus.axi_rid       = rid_q;
    assign bus.axi_rdata     = rdata_q;
    assign bus.axi_rresp     = rresp_q;
    assign bus.axi_rlast     = rlast_q;

    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_write = req_write_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.mem_req_size  = req_size_q;
    assign bus.mem_req_wdata = req_wdata_q;
    assign bus.mem_req_wstrb = req_wstrb_q;

    always_comb begin
        wr_elig  = aw_held_q & w_held_q;
        rd_elig  = ar_held_q;
        sel_any  = wr_elig | rd_elig;
        sel_wr   = wr_elig & (~rd_elig | rr_last_rd_q);
        sel_id   = sel_wr ? aw_id_q   : ar_id_q;
        sel_addr = sel_wr ? aw_addr_q : ar_addr_q;
        sel_size = sel_wr ? aw_size_q : ar_size_q;
        sel_err  = sel_wr ?
                   is_illegal(aw_len_q, aw_burst_q, aw_size_q, aw_addr_q[2:0], 1'b1, w_strb_q, w_last_q) :
                   is_illegal(ar_len_q, ar_burst_q, ar_size_q, ar_addr_q[2:0], 1'b0, 8'h00, 1'b1);
        to_hit   = TO_EN && (to_cnt_q == TO_LAST);

        rsp_fire = 1'b0;
        rsp_wr   = cur_wr_q;
        rsp_id   = cur_id_q;
        rsp_err  = 1'b0;
        rsp_data = 64'd0;
        case (state_q)
            S_IDLE: begin
                if (sel_any && sel_err) begin
                    rsp_fire = 1'b1;
                    rsp_wr   = sel_wr;
                    rsp_id   = sel_id;
                    rsp_err  = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    rsp_fire = 1'b1;
                    rsp_err  = bus.mem_rsp_error;
                    rsp_data = bus.mem_rsp_error ? 64'd0 : bus.mem_rsp_rdata;
                end else if (to_hit) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q      <= S_IDLE;
            rr_last_rd_q <= 1'b1;
            to_cnt_q     <= '0;
            aw_held_q    <= 1'b0;
            aw_id_q      <= '0;
            aw_addr_q    <= '0;
            aw_size_q    <= '0;
            aw_len_q     <= '0;
            aw_burst_q   <= '0;
            w_held_q     <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            w_last_q     <= 1'b0;
            ar_held_q    <= 1'b0;
            ar_id_q      <= '0;
            ar_addr_q    <= '0;
            ar_size_q    <= '0;
            ar_len_q     <= '0;
            ar_burst_q   <= '0;
            cur_wr_q     <= 1'b0;
            cur_id_q     <= '0;
            req_valid_q  <= 1'b0;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_size_q   <= '0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= '0;
            bid_q        <= '0;
            rvalid_q     <= 1'b0;
            rid_q        <= '0;
            rdata_q      <= '0;
            rresp_q      <= '0;
            rlast_q      <= 1'b0;
        end else begin
            if (aw_take) begin
                aw_held_q  <= 1'b1;
                aw_id_q    <= bus.axi_awid;
                aw_addr_q  <= bus.axi_awaddr;
                aw_size_q  <= bus.axi_awsize;
                aw_len_q   <= bus.axi_awlen;
                aw_burst_q <= bus.axi_awburst;
            end
            if (w_take) begin
                w_held_q <= 1'b1;
                w_data_q <= bus.axi_wdata;
                w_strb_q <= bus.axi_wstrb;
                w_last_q <= bus.axi_wlast;
            end
            if (ar_take) begin
                ar_held_q  <= 1'b1;
                ar_id_q    <= bus.axi_arid;
                ar_addr_q  <= bus.axi_araddr;
                ar_size_q  <= bus.axi_arsize;
                ar_len_q   <= bus.axi_arlen;
                ar_burst_q <= bus.axi_arburst;
            end

            case (state_q)
                S_IDLE: begin
                    if (sel_any) begin
                        rr_last_rd_q <= ~sel_wr;
                        cur_wr_q     <= sel_wr;
                        cur_id_q     <= sel_id;
                        if (sel_wr) begin
                            aw_held_q <= 1'b0;
                            w_held_q  <= 1'b0;
                        end else begin
                            ar_held_q <= 1'b0;
                        end
                        if (!sel_err) begin
                            state_q     <= S_CMD;
                            req_valid_q <= 1'b1;
                            req_write_q <= sel_wr;
                            req_addr_q  <= sel_addr;
                            req_size_q  <= sel_size;
                            req_wdata_q <= sel_wr ? w_data_q : 64'd0;
                            req_wstrb_q <= sel_wr ? w_strb_q : 8'd0;
                        end
                    end
                end
                S_CMD: begin
                    if (bus.mem_req_ready) begin
                        state_q     <= S_WAIT;
                        to_cnt_q    <= '0;
                        req_valid_q <= 1'b0;
                        req_write_q <= 1'b0;
                        req_addr_q  <= '0;
                        req_size_q  <= '0;
                        req_wdata_q <= '0;
                        req_wstrb_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (!rsp_fire) begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (cur_wr_q ? bus.axi_bready : bus.axi_rready) begin
                        state_q  <= S_IDLE;
                        bvalid_q <= 1'b0;
                        bresp_q  <= '0;
                        bid_q    <= '0;
                        rvalid_q <= 1'b0;
                        rid_q    <= '0;
                        rdata_q  <= '0;
                        rresp_q  <= '0;
                        rlast_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Response registers load on the same edge that enters RESP, from IDLE or WAIT.
            if (rsp_fire) begin
                state_q <= S_RESP;
                if (rsp_wr) begin
                    bvalid_q <= 1'b1;
                    bresp_q  <= rsp_err ? RESP_ERR : RESP_OK;
                    bid_q    <= rsp_id;
                end else begin
                    rvalid_q <= 1'b1;
                    rid_q    <= rsp_id;
                    rdata_q  <= rsp_data;
                    rresp_q  <= rsp_err ? RESP_ERR : RESP_OK;
                    rlast_q  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/axi4_to_mem_req.md
Name: axi4_to_mem_req

Overview:
- AXI4 slave that consumes the single-beat AXI transactions produced by the AHB-to-AXI4 bridge.
- Converts each transaction into one request on a simple valid/ready memory request port (DMA-side port of the core) and returns the B/R response.
- One transaction outstanding at a time.
- Screens illegal AXI attributes and returns SLVERR for them without issuing a memory request.

Parameters:
TAG, 1, width of AXI ID fields
TIMEOUT, 255, cycles to wait for mem_rsp_valid before answering SLVERR; 0 disables the timeout
TO_W, 8, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  core clock
rst_l  in  1  reset, synchronous, active-low
axi_awvalid  in  1  write address valid
axi_awready  out  1  write address ready
axi_awid  in  TAG  write ID
axi_awaddr  in  32  write address
axi_awsize  in  3  write size
axi_awlen  in  8  burst length-1
axi_awburst  in  2  burst type
axi_wvalid  in  1  write data valid
axi_wready  out  1  write data ready
axi_wdata  in  64  write data
axi_wstrb  in  8  byte strobes
axi_wlast  in  1  last beat
axi_bvalid  out  1  write response valid
axi_bready  in  1  write response ready
axi_bresp  out  2  write response
axi_bid  out  TAG  write response ID
axi_arvalid  in  1  read address valid
axi_arready  out  1  read address ready
axi_arid  in  TAG  read ID
axi_araddr  in  32  read address
axi_arsize  in  3  read size
axi_arlen  in  8  burst length-1
axi_arburst  in  2  burst type
axi_rvalid  out  1  read data valid
axi_rready  in  1  read data ready
axi_rid  out  TAG  read ID
axi_rdata  out  64  read data
axi_rresp  out  2  read response
axi_rlast  out  1  always 1 when rvalid
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1=write
mem_req_addr  out  32  byte address
mem_req_size  out  3  size code 0..3
mem_req_wdata  out  64  write data
mem_req_wstrb  out  8  byte strobes
mem_rsp_valid  in  1  response valid (single cycle)
mem_rsp_rdata  in  64  read data
mem_rsp_error  in  1  response error

Behaviour:
- Reset (rst_l=0 at posedge):
  - All AW/W/AR holding buffers cleared.
  - state=IDLE, rr_last=read, timeout counter=0.
  - bvalid, rvalid, mem_req_valid = 0.
  - awready, wready, arready = 0 during the reset cycle.
  - All data outputs 0.
- Capture:
  - Three independent one-entry holding buffers: AW, W, AR.
  - axi_awready = ~aw_held; axi_wready = ~w_held; axi_arready = ~ar_held (registered held flags). Each is 0 while rst_l=0.
  - A buffer loads on valid&ready and clears when the transaction that consumed it leaves IDLE.
  - AW and W may arrive in either order or in the same cycle.
- Arbitration, IDLE only:
  - A write is eligible when aw_held&w_held; a read is eligible when ar_held.
  - If both are eligible, serve the class opposite rr_last. rr_last updates on selection.
- Legality check at selection; any of the following is an error:
  - len!=0.
  - burst!=INCR(2'b01).
  - size>3.
  - Address not aligned to size.
  - For writes: wlast=0, or any wstrb bit set outside the size/alignment lane mask.
- States:
  - IDLE -> CMD if legal; IDLE -> RESP with err=1 if illegal.
  - CMD: mem_req_valid=1 with fields held stable. On mem_req_ready -> WAIT (counter=0).
  - WAIT: counter increments each cycle.
    - On mem_rsp_valid: capture rdata/error -> RESP.
    - If TIMEOUT!=0 and counter==TIMEOUT-1 without a response: err=1 -> RESP.
  - RESP:
    - Write: bvalid=1, bresp=err?2'b10:2'b00, bid=captured awid.
    - Read: rvalid=1, rlast=1, rid=captured arid, rdata=err?0:captured rdata, rresp likewise.
    - Holds until bready/rready -> IDLE.
- Latency: AW+W accepted in cycle N -> mem_req_valid in cycle N+2. With mem_req_ready=1 and a response on the next cycle, bvalid is asserted in cycle N+4.
- mem_rsp_valid outside WAIT is ignored (late response after a timeout).
- New AXI requests may be captured into empty buffers in any state; the arbiter acts only in IDLE.
- mem_req_* fields are 0 when mem_req_valid=0.

Test Plan:
- Same-cycle AW(id=1, addr=0x1000, size=2) + W(data=0x11223344, wstrb=0x0F, wlast=1); mem_req_ready=1; mem_rsp one cycle later, error=0 -> mem_req_valid cycle N+2 with write=1, addr=0x1000, size=2, wstrb=0x0F; bvalid cycle N+4, bresp=0, bid=1.
- W arrives 3 cycles before AW -> wready=0 after capture; no mem request until AW arrives; then same response as above.
- AR(id=0, addr=0x2008, size=3); mem_rsp_rdata=0xDEADBEEF_CAFEF00D -> rvalid, rdata matches, rresp=0, rlast=1. Hold rready=0 for 5 cycles -> rvalid and rdata held stable.
- AR with addr=0x2002, size=2 (unaligned), and separately AW with awlen=3 -> no mem_req_valid, SLVERR (2'b10) response.
- Write and read both held in IDLE, rr_last=read -> write served first, then the read.
- TIMEOUT=4, no mem_rsp -> SLVERR after 4 cycles in WAIT; later mem_rsp_valid ignored.
- Assert rst_l=0 in WAIT and in RESP -> next cycle state IDLE, all valids 0, buffers empty.
